basic_control_unit: RTL
=======================

Name: basic_control_unit

Overview:
- Hardwired control unit that sequences the common-bus datapath through fetch, decode, indirect, execute and (optionally) interrupt cycles.
- Contains a 4-bit sequence counter (SC), a halt flag and an interrupt flip-flop R.
- Decodes IR, AC, DR, E and the flag outputs into per-cycle LD/INC/CLR, bus select, ALU op and memory strobes for the datapath.

Parameters:
- SC_W, 4, sequence counter width (timing states T0..T15)

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- IR_OUT  input  16  instruction register
- AC_OUT  input  16  accumulator
- DR_OUT  input  16  data register
- OUT_E, OUT_FGI, OUT_FGO, OUT_INE  input  1 each  E flip-flop, input flag, output flag, interrupt enable
- LD_AR, LD_PC, LD_DR, LD_IR, LD_TR, LD_OUTR, LD_AC  output  1 each  register loads
- INC_AR, INC_PC, INC_DR, INC_TR, INC_AC  output  1 each  register increments
- CLR_AR, CLR_PC, CLR_DR, CLR_TR, CLR_AC  output  1 each  register clears
- Read_memory, Write_memory  output  1 each  memory strobes
- Sel  output  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
- aluop  output  4  0 AND, 1 ADD, 2 pass DR, 3 CMA, 4 CIR, 5 CIL, 6 INPR, 7 CME, 8 CLE
- Write_E  output  1  load E from ALU
- SET_INE, reset_INE, reset_FGI, reset_FGO  output  1 each  flag controls
- halted  output  1  HLT executed
- sc_out  output  SC_W  current timing state, for debug

Behaviour:
- Reset (reset==0 at a clock edge): SC=0, halted=0, R=0.
  - All control outputs are forced to 0 while reset is low.
  - The first cycle after release is T0.
- Controls are combinational from SC, R, IR and the status inputs.
- Unlisted outputs are 0 in every state.
- SC increments each cycle. "SC<-0" means SC returns to T0 on the next edge.
- Fields: I=IR_OUT[15], op=IR_OUT[14:12], B=IR_OUT[11:0].
- Fetch (R=0):
  - T0: Sel=2, LD_AR.
  - T1: Sel=7, Read_memory, LD_IR, INC_PC.
  - T2: Sel=5, LD_AR.
- T3, op!=7, I=1: Sel=7, Read_memory, LD_AR. I=0: no action.
- Memory reference (T4 onward):
  - AND/ADD/LDA (op 0/1/2):
    - T4: Sel=7, Read_memory, LD_DR.
    - T5: aluop 0/1/2, LD_AC, SC<-0. ADD also asserts Write_E.
  - STA (3): T4: Sel=4, Write_memory, SC<-0.
  - BUN (4): T4: Sel=5, LD_PC, SC<-0.
  - BSA (5):
    - T4: Sel=2, Write_memory, INC_AR.
    - T5: Sel=1, LD_PC, SC<-0.
  - ISZ (6):
    - T4: read to DR (as for AND).
    - T5: INC_DR.
    - T6: Sel=3, Write_memory; INC_PC if DR_OUT==0; SC<-0.
- Register reference (op=7, I=0), at T3, then SC<-0.
  - Only the highest-index set bit of B executes.
  - B11 CLR_AC
  - B10 aluop 8 + Write_E
  - B9 aluop 3 + LD_AC
  - B8 aluop 7 + Write_E
  - B7 aluop 4 + LD_AC + Write_E
  - B6 aluop 5 + LD_AC + Write_E
  - B5 INC_AC
  - B4 INC_PC if AC_OUT[15]==0
  - B3 INC_PC if AC_OUT[15]==1
  - B2 INC_PC if AC_OUT==0
  - B1 INC_PC if OUT_E==0
  - B0 halted<=1
  - B==0: no operation.
- I/O (op=7, I=1), at T3, then SC<-0, same priority rule:
  - B11 aluop 6 + LD_AC + reset_FGI
  - B10 Sel=4 + LD_OUTR + reset_FGO
  - B9 INC_PC if OUT_FGI
  - B8 INC_PC if OUT_FGO
  - B7 SET_INE
  - B6 reset_INE
- Halted: SC holds at 0 and all control outputs are 0. Only reset clears halted.
- SC wraps only via SC<-0. A state beyond T6 with no action is treated as illegal: SC<-0.

Optional Feature:
- Macro: INTERRUPT_EN.
- Defined:
  - R<=1 on any edge where SC is not T0/T1/T2, OUT_INE=1, (OUT_FGI|OUT_FGO)=1 and halted=0.
  - With R=1 the next T0..T2 run the interrupt cycle instead of fetch:
    - T0: CLR_AR, Sel=2, LD_TR.
    - T1: Sel=6, Write_memory, CLR_PC.
    - T2: INC_PC, reset_INE, R<=0, SC<-0.
- Not defined: R is held at 0 and the interrupt cycle is never entered. ION/IOF still drive SET_INE/reset_INE.

Test Plan:
- Reset low 2 cycles, release -> all outputs 0 during reset; next cycle Sel=2, LD_AR=1, sc_out=0.
- Word 0x2004 (LDA direct) -> T4 LD_DR with Sel=7; T5 aluop=2, LD_AC; sc_out returns 0 after 6 cycles total.
- Word 0xE00A (ISZ indirect), M[A]=0xFFFF -> T3 LD_AR from memory; T6 Sel=3, Write_memory, INC_PC=1.
- Word 0x7010 (SPA) with AC_OUT=0x7FFF -> INC_PC=1 at T3. With AC_OUT=0x8000 -> INC_PC=0.
- Word 0x7001 (HLT) -> halted=1 after T3; then 10 cycles of all-zero outputs; reset clears halted.
- INTERRUPT_EN, OUT_INE=1, FGI=1 during a T3 -> next T0 CLR_AR+LD_TR(Sel=2); T1 Sel=6, Write_memory, CLR_PC; T2 INC_PC, reset_INE.

Source files
------------

// File: rtl/basic_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : basic_control_unit_if
// Description : Status/control bundle between the hardwired control unit
//               (master) and the common-bus datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface basic_control_unit_if #(
  parameter int SC_W = 4
);
  // Datapath status into the control unit
  logic [15:0]     IR_OUT;
  logic [15:0]     AC_OUT;
  logic [15:0]     DR_OUT;
  logic            OUT_E;
  logic            OUT_FGI;
  logic            OUT_FGO;
  logic            OUT_INE;

  // Register controls
  logic            LD_AR, LD_PC, LD_DR, LD_IR, LD_TR, LD_OUTR, LD_AC;
  logic            INC_AR, INC_PC, INC_DR, INC_TR, INC_AC;
  logic            CLR_AR, CLR_PC, CLR_DR, CLR_TR, CLR_AC;

  // Memory, bus and ALU controls
  logic            Read_memory, Write_memory;
  logic [2:0]      Sel;
  logic [3:0]      aluop;
  logic            Write_E;

  // Flag controls and status
  logic            SET_INE, reset_INE, reset_FGI, reset_FGO;
  logic            halted;
  logic [SC_W-1:0] sc_out;

  modport master (
    input  IR_OUT, AC_OUT, DR_OUT, OUT_E, OUT_FGI, OUT_FGO, OUT_INE,
    output LD_AR, LD_PC, LD_DR, LD_IR, LD_TR, LD_OUTR, LD_AC,
    output INC_AR, INC_PC, INC_DR, INC_TR, INC_AC,
    output CLR_AR, CLR_PC, CLR_DR, CLR_TR, CLR_AC,
    output Read_memory, Write_memory, Sel, aluop, Write_E,
    output SET_INE, reset_INE, reset_FGI, reset_FGO, halted, sc_out
  );

  modport slave (
    output IR_OUT, AC_OUT, DR_OUT, OUT_E, OUT_FGI, OUT_FGO, OUT_INE,
    input  LD_AR, LD_PC, LD_DR, LD_IR, LD_TR, LD_OUTR, LD_AC,
    input  INC_AR, INC_PC, INC_DR, INC_TR, INC_AC,
    input  CLR_AR, CLR_PC, CLR_DR, CLR_TR, CLR_AC,
    input  Read_memory, Write_memory, Sel, aluop, Write_E,
    input  SET_INE, reset_INE, reset_FGI, reset_FGO, halted, sc_out
  );
endinterface

`default_nettype wire

// File: rtl/basic_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : basic_control_unit
// Description : Hardwired control unit for the common-bus basic computer.
//               Sequences fetch / indirect / execute (and, when the macro
//               INTERRUPT_EN is defined, the interrupt cycle) from a
//               sequence counter, a halt flag and the interrupt flop R.
// Revision    : 1.0 - initial release
// ============================================================================
module basic_control_unit #(
  parameter int SC_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  basic_control_unit_if.master bus
);

  localparam logic [SC_W-1:0] T0     = SC_W'(0);
  localparam logic [SC_W-1:0] T1     = SC_W'(1);
  localparam logic [SC_W-1:0] T2     = SC_W'(2);
  localparam logic [SC_W-1:0] T3     = SC_W'(3);
  localparam logic [SC_W-1:0] T4     = SC_W'(4);
  localparam logic [SC_W-1:0] T5     = SC_W'(5);
  localparam logic [SC_W-1:0] T6     = SC_W'(6);
  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_AR   = 3'd1;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_DR   = 3'd3;
  localparam logic [2:0] SEL_AC   = 3'd4;
  localparam logic [2:0] SEL_IR   = 3'd5;
  localparam logic [2:0] SEL_TR   = 3'd6;
  localparam logic [2:0] SEL_MEM  = 3'd7;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd2;
  localparam logic [3:0] ALU_CMA  = 4'd3;
  localparam logic [3:0] ALU_CIR  = 4'd4;
  localparam logic [3:0] ALU_CIL  = 4'd5;
  localparam logic [3:0] ALU_INPR = 4'd6;
  localparam logic [3:0] ALU_CME  = 4'd7;
  localparam logic [3:0] ALU_CLE  = 4'd8;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RIO = 3'd7;

  logic [SC_W-1:0] sc_q, sc_d;
  logic            halted_q, halted_d;
  logic            r_q, r_d;

  logic            ind;
  logic [2:0]      op;
  logic [11:0]     b;

  assign ind = bus.IR_OUT[15];
  assign op  = bus.IR_OUT[14:12];
  assign b   = bus.IR_OUT[11:0];

  // Decode timing state, R and IR into this cycle's controls and next state
  always_comb begin
    bus.LD_AR = 1'b0;  bus.LD_PC = 1'b0;  bus.LD_DR = 1'b0;  bus.LD_IR = 1'b0;
    bus.LD_TR = 1'b0;  bus.LD_OUTR = 1'b0; bus.LD_AC = 1'b0;
    bus.INC_AR = 1'b0; bus.INC_PC = 1'b0; bus.INC_DR = 1'b0; bus.INC_TR = 1'b0;
    bus.INC_AC = 1'b0;
    bus.CLR_AR = 1'b0; bus.CLR_PC = 1'b0; bus.CLR_DR = 1'b0; bus.CLR_TR = 1'b0;
    bus.CLR_AC = 1'b0;
    bus.Read_memory = 1'b0; bus.Write_memory = 1'b0;
    bus.Sel = SEL_NONE; bus.aluop = ALU_AND; bus.Write_E = 1'b0;
    bus.SET_INE = 1'b0; bus.reset_INE = 1'b0; bus.reset_FGI = 1'b0;
    bus.reset_FGO = 1'b0;
    sc_d     = sc_q + SC_ONE;
    halted_d = halted_q;
    r_d      = r_q;

    if (halted_q) begin
      // A halted machine parks at T0 with every control idle
      sc_d = T0;
    end else if (reset) begin
      case (sc_q)
        T0: begin
          bus.Sel = SEL_PC;
          if (r_q) begin
            bus.CLR_AR = 1'b1;
            bus.LD_TR  = 1'b1;
          end else begin
            bus.LD_AR  = 1'b1;
          end
        end
        T1: begin
          if (r_q) begin
            bus.Sel = SEL_TR; bus.Write_memory = 1'b1; bus.CLR_PC = 1'b1;
          end else begin
            bus.Sel = SEL_MEM; bus.Read_memory = 1'b1;
            bus.LD_IR = 1'b1;  bus.INC_PC = 1'b1;
          end
        end
        T2: begin
          if (r_q) begin
            bus.INC_PC = 1'b1; bus.reset_INE = 1'b1;
            r_d = 1'b0;        sc_d = T0;
          end else begin
            bus.Sel = SEL_IR; bus.LD_AR = 1'b1;
          end
        end
        T3: begin
          if (op == OP_RIO) begin
            sc_d = T0;
            // Only the highest set bit of B executes
            if (!ind) begin
              if      (b[11]) bus.CLR_AC = 1'b1;
              else if (b[10]) begin bus.aluop = ALU_CLE; bus.Write_E = 1'b1; end
              else if (b[9])  begin bus.aluop = ALU_CMA; bus.LD_AC = 1'b1; end
              else if (b[8])  begin bus.aluop = ALU_CME; bus.Write_E = 1'b1; end
              else if (b[7])  begin
                bus.aluop = ALU_CIR; bus.LD_AC = 1'b1; bus.Write_E = 1'b1;
              end
              else if (b[6])  begin
                bus.aluop = ALU_CIL; bus.LD_AC = 1'b1; bus.Write_E = 1'b1;
              end
              else if (b[5])  bus.INC_AC = 1'b1;
              else if (b[4])  bus.INC_PC = ~bus.AC_OUT[15];
              else if (b[3])  bus.INC_PC = bus.AC_OUT[15];
              else if (b[2])  bus.INC_PC = (bus.AC_OUT == 16'h0000);
              else if (b[1])  bus.INC_PC = ~bus.OUT_E;
              else if (b[0])  halted_d = 1'b1;
            end else begin
              if      (b[11]) begin
                bus.aluop = ALU_INPR; bus.LD_AC = 1'b1; bus.reset_FGI = 1'b1;
              end
              else if (b[10]) begin
                bus.Sel = SEL_AC; bus.LD_OUTR = 1'b1; bus.reset_FGO = 1'b1;
              end
              else if (b[9])  bus.INC_PC = bus.OUT_FGI;
              else if (b[8])  bus.INC_PC = bus.OUT_FGO;
              else if (b[7])  bus.SET_INE = 1'b1;
              else if (b[6])  bus.reset_INE = 1'b1;
            end
          end else if (ind) begin
            // Indirect: replace the address with the word it points to
            bus.Sel = SEL_MEM; bus.Read_memory = 1'b1; bus.LD_AR = 1'b1;
          end
        end
        T4: begin
          case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus.Sel = SEL_MEM; bus.Read_memory = 1'b1; bus.LD_DR = 1'b1;
            end
            OP_STA: begin
              bus.Sel = SEL_AC; bus.Write_memory = 1'b1; sc_d = T0;
            end
            OP_BUN: begin
              bus.Sel = SEL_IR; bus.LD_PC = 1'b1; sc_d = T0;
            end
            OP_BSA: begin
              bus.Sel = SEL_PC; bus.Write_memory = 1'b1; bus.INC_AR = 1'b1;
            end
            default: sc_d = T0;
          endcase
        end
        T5: begin
          case (op)
            OP_AND: begin bus.aluop = ALU_AND;  bus.LD_AC = 1'b1; sc_d = T0; end
            OP_ADD: begin
              bus.aluop = ALU_ADD; bus.LD_AC = 1'b1; bus.Write_E = 1'b1; sc_d = T0;
            end
            OP_LDA: begin bus.aluop = ALU_PASS; bus.LD_AC = 1'b1; sc_d = T0; end
            OP_BSA: begin bus.Sel = SEL_AR; bus.LD_PC = 1'b1; sc_d = T0; end
            OP_ISZ: bus.INC_DR = 1'b1;
            default: sc_d = T0;
          endcase
        end
        T6: begin
          sc_d = T0;
          if (op == OP_ISZ) begin
            bus.Sel = SEL_DR; bus.Write_memory = 1'b1;
            bus.INC_PC = (bus.DR_OUT == 16'h0000);
          end
        end
        // States past T6 carry no work; send them back to T0
        default: sc_d = T0;
      endcase
    end

`ifdef INTERRUPT_EN
    // Arm the interrupt cycle outside fetch when an enabled flag is raised
    if (reset && !halted_q && (sc_q != T0) && (sc_q != T1) && (sc_q != T2) &&
        bus.OUT_INE && (bus.OUT_FGI || bus.OUT_FGO)) begin
      r_d = 1'b1;
    end
`else
    r_d = 1'b0;
`endif
  end

`ifndef INTERRUPT_EN
  logic unused_ine;
  assign unused_ine = bus.OUT_INE;
`endif

  // Sequence counter, halt flag and interrupt flop; synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      sc_q     <= T0;
      halted_q <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      sc_q     <= sc_d;
      halted_q <= halted_d;
      r_q      <= r_d;
    end
  end

  assign bus.halted = halted_q;
  assign bus.sc_out = sc_q;

endmodule

`default_nettype wire
